// File: rtl/iter_alu.sv
// iter_alu: registered ALU with iterative MULU/DIVU behind a valid/ready input.
// Ports: clk, rst_n, in_valid/in_ready, in1, in2, ctrl -> out_valid, out, out_hi, zero, ovf, dz.
module iter_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       ctrl,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             zero,
  output logic             ovf,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_W = CW'(WIDTH);

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SLT  = 4'b0111;
  localparam logic [3:0] C_SLTU = 4'b1101;
  localparam logic [3:0] C_NOR  = 4'b1100;
  localparam logic [3:0] C_MULU = 4'b0011;
  localparam logic [3:0] C_DIVU = 4'b0100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_e;

  state_e state_q, state_d;

  // a: accumulator / partial remainder
  // b: multiplier / dividend-quotient
  // c: multiplicand / divisor
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             dz_q, dz_d;
  logic             vld_q, vld_d;

  logic accept;
  logic in2_nz;
  logic last;

  assign accept = in_valid && in_ready;
  assign in2_nz = (in2 != '0);
  assign last   = (cnt_q == CW'(1));

  // single-cycle result path
  logic op_and, op_or, op_add, op_sub;
  logic op_slt, op_sltu, op_nor, op_divu;

  assign op_and  = (ctrl == C_AND);
  assign op_or   = (ctrl == C_OR);
  assign op_add  = (ctrl == C_ADD);
  assign op_sub  = (ctrl == C_SUB);
  assign op_slt  = (ctrl == C_SLT);
  assign op_sltu = (ctrl == C_SLTU);
  assign op_nor  = (ctrl == C_NOR);
  assign op_divu = (ctrl == C_DIVU);

  logic [WIDTH-1:0] add_r, sub_r;
  logic             slt_r, sltu_r;

  assign add_r  = in1 + in2;
  assign sub_r  = in1 - in2;
  assign slt_r  = $signed(in1) < $signed(in2);
  assign sltu_r = in1 < in2;

  logic [WIDTH-1:0] alu_res, alu_hi;
  logic             alu_ovf, alu_dz;

  always_comb begin
    alu_res = '0;
    alu_hi  = '0;
    alu_ovf = 1'b0;
    alu_dz  = 1'b0;
    unique case (1'b1)
      op_and:  alu_res = in1 & in2;
      op_or:   alu_res = in1 | in2;
      op_nor:  alu_res = ~(in1 | in2);
      op_add: begin
        alu_res = add_r;
        alu_ovf = (in1[WIDTH-1] == in2[WIDTH-1])
               && (add_r[WIDTH-1] != in1[WIDTH-1]);
      end
      op_sub: begin
        alu_res = sub_r;
        alu_ovf = (in1[WIDTH-1] != in2[WIDTH-1])
               && (sub_r[WIDTH-1] != in1[WIDTH-1]);
      end
      op_slt:  alu_res = {{(WIDTH-1){1'b0}}, slt_r};
      op_sltu: alu_res = {{(WIDTH-1){1'b0}}, sltu_r};
      // only reached with a zero divisor
      op_divu: begin
        alu_res = '1;
        alu_hi  = in1;
        alu_dz  = 1'b1;
      end
      default: ;
    endcase
  end

  // one shift-add step: carry out of the add shifts into the top
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc, mul_lo;

  assign mul_sum = {1'b0, a_q} + {1'b0, (b_q[0] ? c_q : '0)};
  assign mul_acc = mul_sum[WIDTH:1];
  assign mul_lo  = {mul_sum[0], b_q[WIDTH-1:1]};

  // one restoring-divide step: borrow in the top bit means restore
  logic [WIDTH:0]   div_trial, div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] div_rem, div_quo;

  assign div_trial = {a_q, b_q[WIDTH-1]};
  assign div_diff  = div_trial - {1'b0, c_q};
  assign div_ok    = ~div_diff[WIDTH];
  assign div_rem   = div_ok ? div_diff[WIDTH-1:0]
                            : div_trial[WIDTH-1:0];
  assign div_quo   = {b_q[WIDTH-2:0], div_ok};

  // state register and datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      hi_q    <= hi_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
      vld_q   <= vld_d;
    end
  end

  // next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (ctrl == C_MULU)
            state_d = MUL;
          else if (op_divu && in2_nz)
            state_d = DIV;
        end
      end
      MUL, DIV: begin
        if (last)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs and datapath next values
  always_comb begin
    in_ready = (state_q == IDLE);
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    dz_d     = dz_q;
    vld_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (ctrl == C_MULU) begin
            a_d   = '0;
            b_d   = in2;
            c_d   = in1;
            cnt_d = CNT_W;
          end else if (op_divu && in2_nz) begin
            a_d   = '0;
            b_d   = in1;
            c_d   = in2;
            cnt_d = CNT_W;
          end else begin
            out_d  = alu_res;
            hi_d   = alu_hi;
            zero_d = (alu_res == '0);
            ovf_d  = alu_ovf;
            dz_d   = alu_dz;
            vld_d  = 1'b1;
          end
        end
      end
      MUL: begin
        a_d   = mul_acc;
        b_d   = mul_lo;
        cnt_d = cnt_q - CW'(1);
        if (last) begin
          out_d  = mul_lo;
          hi_d   = mul_acc;
          zero_d = (mul_lo == '0);
          ovf_d  = 1'b0;
          dz_d   = 1'b0;
          vld_d  = 1'b1;
        end
      end
      DIV: begin
        a_d   = div_rem;
        b_d   = div_quo;
        cnt_d = cnt_q - CW'(1);
        if (last) begin
          out_d  = div_quo;
          hi_d   = div_rem;
          zero_d = (div_quo == '0);
          ovf_d  = 1'b0;
          dz_d   = 1'b0;
          vld_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign out_valid = vld_q;
  assign out       = out_q;
  assign out_hi    = hi_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: directed self-checking bench for iter_alu.
// Drives a WIDTH=32 and a WIDTH=8 instance from one clock and reset.
module tb_iter_alu;

  localparam logic [3:0] AND_ = 4'b0000;
  localparam logic [3:0] OR_  = 4'b0001;
  localparam logic [3:0] ADD  = 4'b0010;
  localparam logic [3:0] SUB  = 4'b0110;
  localparam logic [3:0] SLT  = 4'b0111;
  localparam logic [3:0] SLTU = 4'b1101;
  localparam logic [3:0] NOR_ = 4'b1100;
  localparam logic [3:0] MULU = 4'b0011;
  localparam logic [3:0] DIVU = 4'b0100;
  localparam logic [3:0] BAD  = 4'b1111;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic        v32 = 1'b0;
  logic        rdy32;
  logic [31:0] a32 = '0;
  logic [31:0] b32 = '0;
  logic [3:0]  c32 = '0;
  logic        ov32;
  logic [31:0] o32, h32;
  logic        z32, f32, d32;

  logic        v8 = 1'b0;
  logic        rdy8;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic [3:0]  c8 = '0;
  logic        ov8;
  logic [7:0]  o8, h8;
  logic        z8, f8, d8;

  iter_alu #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v32), .in_ready(rdy32),
    .in1(a32), .in2(b32), .ctrl(c32),
    .out_valid(ov32), .out(o32), .out_hi(h32),
    .zero(z32), .ovf(f32), .dz(d32)
  );

  iter_alu #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v8), .in_ready(rdy8),
    .in1(a8), .in2(b8), .ctrl(c8),
    .out_valid(ov8), .out(o8), .out_hi(h8),
    .zero(z8), .ovf(f8), .dz(d8)
  );

  // Issue one op, optionally keep in_valid high with junk while busy,
  // and stop at the negedge where out_valid is seen (lat = -1 on timeout).
  task automatic run32(input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input bit hold,
                       output int lat, output int busy);
    @(negedge clk);
    v32 = 1'b1; c32 = c; a32 = a; b32 = b;
    @(posedge clk);
    #1;
    if (hold) begin
      c32 = ADD; a32 = 32'h1; b32 = 32'h2;
    end else v32 = 1'b0;
    lat = -1; busy = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ov32) begin
        lat = n;
        break;
      end
      if (!rdy32) busy++;
    end
    v32 = 1'b0;
  endtask

  task automatic run8(input logic [3:0] c, input logic [7:0] a,
                      input logic [7:0] b, output int lat);
    @(negedge clk);
    v8 = 1'b1; c8 = c; a8 = a; b8 = b;
    @(posedge clk);
    #1 v8 = 1'b0;
    lat = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ov8) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int lat, busy, seen;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({ov32, o32, h32, z32, f32, d32} !== '0) begin
      miscompares++;
      $display("FAIL reset_outs: got %h %h %h %b%b%b want all 0",
               ov32, o32, h32, z32, f32, d32);
    end
    vectors++;
    if (rdy32 !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 1", rdy32);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run32(ADD, 32'd1, 32'd1, 1'b0, lat, busy);
    vectors++;
    if (o32 !== 32'd2) begin
      miscompares++;
      $display("FAIL pre_add: got %h want 2", o32);
    end
    // start a MULU and kill it around iteration 10
    @(negedge clk);
    v32 = 1'b1; c32 = MULU; a32 = 32'hFFFF_FFFF; b32 = 32'd3;
    @(posedge clk);
    #1 v32 = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({ov32, o32, h32, z32, f32, d32} !== '0) begin
      miscompares++;
      $display("FAIL midmul_reset_outs: got %h %h %h %b%b%b want all 0",
               ov32, o32, h32, z32, f32, d32);
    end
    vectors++;
    if (rdy32 !== 1'b1) begin
      miscompares++;
      $display("FAIL midmul_reset_ready: got %b want 1", rdy32);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ov32) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL midmul_no_valid: got %0d pulses want 0", seen);
    end
    run32(ADD, 32'd3, 32'd4, 1'b0, lat, busy);
    vectors++;
    if (lat !== 0 || o32 !== 32'd7) begin
      miscompares++;
      $display("FAIL add_3_4: got lat %0d out %h want lat 0 out 7",
               lat, o32);
    end
  endtask

  task automatic test_flags;
    int lat, busy;
    run32(ADD, 32'h7FFF_FFFF, 32'd1, 1'b0, lat, busy);
    vectors++;
    if (lat !== 0 || o32 !== 32'h8000_0000 || f32 !== 1'b1) begin
      miscompares++;
      $display("FAIL add_ovf: got lat %0d out %h ovf %b want 0 80000000 1",
               lat, o32, f32);
    end
    run32(SUB, 32'd5, 32'd5, 1'b0, lat, busy);
    vectors++;
    if (o32 !== 32'd0 || z32 !== 1'b1 || f32 !== 1'b0) begin
      miscompares++;
      $display("FAIL sub_zero: got out %h zero %b ovf %b want 0 1 0",
               o32, z32, f32);
    end
    run32(SLT, 32'hFFFF_FFFF, 32'd1, 1'b0, lat, busy);
    vectors++;
    if (o32 !== 32'd1 || z32 !== 1'b0) begin
      miscompares++;
      $display("FAIL slt: got out %h zero %b want 1 0", o32, z32);
    end
    run32(SLTU, 32'hFFFF_FFFF, 32'd1, 1'b0, lat, busy);
    vectors++;
    if (o32 !== 32'd0 || z32 !== 1'b1) begin
      miscompares++;
      $display("FAIL sltu: got out %h zero %b want 0 1", o32, z32);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0]  ops [4];
    logic [31:0] exp [4];
    ops = '{AND_, OR_, NOR_, ADD};
    exp = '{32'h00F0_0220, 32'hFFF0_5335, 32'h000F_ACCA, 32'h00E0_5555};
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        vectors++;
        if (ov32 !== 1'b1 || o32 !== exp[i-1]) begin
          miscompares++;
          $display("FAIL b2b_%0d: got valid %b out %h want 1 %h",
                   i - 1, ov32, o32, exp[i-1]);
        end
      end
      if (i < 4) begin
        vectors++;
        if (rdy32 !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_ready_%0d: got %b want 1", i, rdy32);
        end
        v32 = 1'b1; c32 = ops[i];
        a32 = 32'hF0F0_1234; b32 = 32'h0FF0_4321;
      end else v32 = 1'b0;
    end
    @(negedge clk);
    vectors++;
    if (ov32 !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_end: got valid %b want 0", ov32);
    end
  endtask

  task automatic test_mulu;
    int lat, busy;
    run32(MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, lat, busy);
    vectors++;
    if (lat !== 32 || busy !== 32) begin
      miscompares++;
      $display("FAIL mul_timing: got lat %0d busy %0d want 32 32",
               lat, busy);
    end
    vectors++;
    if (h32 !== 32'hFFFF_FFFE || o32 !== 32'h0000_0001 || z32 !== 1'b0) begin
      miscompares++;
      $display("FAIL mul_ff: got hi %h lo %h zero %b want fffffffe 00000001 0",
               h32, o32, z32);
    end
    @(negedge clk);
    vectors++;
    if (ov32 !== 1'b0 || rdy32 !== 1'b1) begin
      miscompares++;
      $display("FAIL mul_stall_ignored: got valid %b ready %b want 0 1",
               ov32, rdy32);
    end
    run32(ADD, 32'd5, 32'd6, 1'b0, lat, busy);
    vectors++;
    if (o32 !== 32'd11 || h32 !== 32'd0) begin
      miscompares++;
      $display("FAIL add_after_mul: got out %h hi %h want 0000000b 0",
               o32, h32);
    end
  endtask

  task automatic test_divu;
    int lat, busy;
    run32(DIVU, 32'd100, 32'd7, 1'b0, lat, busy);
    vectors++;
    if (lat !== 32 || o32 !== 32'd14 || h32 !== 32'd2 || d32 !== 1'b0) begin
      miscompares++;
      $display("FAIL div_100_7: got lat %0d q %h r %h dz %b want 32 e 2 0",
               lat, o32, h32, d32);
    end
    run32(DIVU, 32'h1234_5678, 32'd0, 1'b0, lat, busy);
    vectors++;
    if (lat !== 0 || o32 !== 32'hFFFF_FFFF || h32 !== 32'h1234_5678
        || d32 !== 1'b1) begin
      miscompares++;
      $display("FAIL div_zero: got lat %0d q %h r %h dz %b want 0 ffffffff 12345678 1",
               lat, o32, h32, d32);
    end
  endtask

  task automatic test_width8;
    int lat;
    run8(MULU, 8'd200, 8'd3, lat);
    vectors++;
    if (lat !== 8 || h8 !== 8'h02 || o8 !== 8'h58) begin
      miscompares++;
      $display("FAIL w8_mul: got lat %0d hi %h lo %h want 8 02 58",
               lat, h8, o8);
    end
    run8(DIVU, 8'd255, 8'd16, lat);
    vectors++;
    if (lat !== 8 || o8 !== 8'd15 || h8 !== 8'd15 || d8 !== 1'b0) begin
      miscompares++;
      $display("FAIL w8_div: got lat %0d q %h r %h dz %b want 8 0f 0f 0",
               lat, o8, h8, d8);
    end
    run8(BAD, 8'hA5, 8'h5A, lat);
    vectors++;
    if (lat !== 0 || o8 !== 8'd0 || h8 !== 8'd0 || z8 !== 1'b1) begin
      miscompares++;
      $display("FAIL w8_bad: got lat %0d out %h hi %h zero %b want 0 00 00 1",
               lat, o8, h8, z8);
    end
  endtask

  initial begin
    test_reset();
    test_flags();
    test_back_to_back();
    test_mulu();
    test_divu();
    test_width8();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
